// File: rtl/d_ff_pkg.sv
// rtl/d_ff_pkg.sv - shared state encoding and default sizing for the input debouncer
package d_ff_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    QUAL_HI   = 2'b01,
    STABLE_HI = 2'b10,
    QUAL_LO   = 2'b11
  } dbnc_state_t;

  localparam int DEFAULT_STABLE_CYCLES = 4;
  localparam int DEFAULT_CNT_W         = 16;

  function automatic logic is_qualifying(input dbnc_state_t s);
    return (s == QUAL_HI) || (s == QUAL_LO);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic sync1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      sync1    <= async_in;
      sync_out <= sync1;
    end
  end

endmodule

// File: rtl/d_input_debouncer.sv
// rtl/d_input_debouncer.sv - debounces a raw pin: a new level must hold STABLE_CYCLES synchronized cycles
module d_input_debouncer
  import d_ff_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic d_clean,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic          sync2;
  dbnc_state_t   state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (din),
    .sync_out (sync2)
  );

  // Outputs are registered alongside the state so nothing combinational reaches din.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= STABLE_LO;
      cnt        <= '0;
      d_clean    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (sync2) begin
            state <= QUAL_HI;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        QUAL_HI: begin
          if (!sync2) begin
            state <= STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state      <= STABLE_HI;
            cnt        <= '0;
            d_clean    <= 1'b1;
            rise_pulse <= 1'b1;
            busy       <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!sync2) begin
            state <= QUAL_LO;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        QUAL_LO: begin
          if (sync2) begin
            state <= STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state      <= STABLE_LO;
            cnt        <= '0;
            d_clean    <= 1'b0;
            fall_pulse <= 1'b1;
            busy       <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state   <= STABLE_LO;
          cnt     <= '0;
          d_clean <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_input_debouncer.sv
// tb/tb_d_input_debouncer.sv - randomized and directed self-checking bench for d_input_debouncer
module tb_d_input_debouncer;
  import d_ff_pkg::*;

  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic d_clean, rise_pulse, fall_pulse, busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference: din reaches the qualifier two edges late; a level different from the
  // accepted one is adopted once it has been seen on SC consecutive edges.
  logic m_dly [2];
  logic m_clean, m_rise, m_fall;
  int   m_run;
  int   max_cnt;

  d_input_debouncer #(.STABLE_CYCLES(SC), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .d_clean    (d_clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic d, input logic r);
    logic seen;
    din   = d;
    rst_n = r;
    @(posedge clk);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!r) begin
      m_dly[0] = 1'b0; m_dly[1] = 1'b0;
      m_clean = 1'b0; m_run = 0;
    end else begin
      seen = m_dly[1];
      if (seen != m_clean) begin
        m_run++;
        if (m_run == SC) begin
          m_clean = seen;
          m_rise  = seen;
          m_fall  = !seen;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_dly[1] = m_dly[0];
      m_dly[0] = d;
    end
    #1;
    vectors++;
    if ({d_clean, rise_pulse, fall_pulse, busy} !== {m_clean, m_rise, m_fall, (m_run != 0)}) begin
      miscompares++;
      $display("FAIL outputs t=%0t got clean/rise/fall/busy=%b%b%b%b want %b%b%b%b", $time,
               d_clean, rise_pulse, fall_pulse, busy, m_clean, m_rise, m_fall, (m_run != 0));
    end
    vectors++;
    if (rise_pulse && fall_pulse) begin
      miscompares++;
      $display("FAIL pulse_exclusive t=%0t got rise=1 fall=1 want not both", $time);
    end
    vectors++;
    if (dut.cnt >= 16'(SC)) begin
      miscompares++;
      $display("FAIL cnt_bound t=%0t got cnt=%0d want < %0d", $time, dut.cnt, SC);
    end
    if (int'(dut.cnt) > max_cnt) max_cnt = int'(dut.cnt);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    vectors++;
    if ({d_clean, rise_pulse, fall_pulse, busy} !== 4'b0000 || dut.state !== STABLE_LO || dut.cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state got %b%b%b%b state=%0d cnt=%0d want 0000 state=0 cnt=0",
               d_clean, rise_pulse, fall_pulse, busy, dut.state, dut.cnt);
    end
  endtask

  // Hold din at level d until d_clean reaches it; report the edge and side effects.
  task automatic hold_until(input logic d, output int first, output int rises,
                            output int falls, output int busy_cyc);
    first = 0; rises = 0; falls = 0; busy_cyc = 0;
    for (int i = 1; i <= 14; i++) begin
      tick(d, 1'b1);
      rises += int'(rise_pulse);
      falls += int'(fall_pulse);
      if (first == 0) busy_cyc += int'(busy);
      if (first == 0 && d_clean == d) first = i;
    end
  endtask

  task automatic test_clean_rise();
    int first, rises, falls, bc;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    hold_until(1'b1, first, rises, falls, bc);
    vectors++;
    if (first != 2 + SC || rises != 1 || falls != 0 || bc != SC - 1) begin
      miscompares++;
      $display("FAIL clean_rise got edge=%0d rises=%0d falls=%0d busy=%0d want %0d 1 0 %0d",
               first, rises, falls, bc, 2 + SC, SC - 1);
    end
  endtask

  task automatic test_clean_fall();
    int first, rises, falls, bc;
    hold_until(1'b0, first, rises, falls, bc);
    vectors++;
    if (first != 2 + SC || rises != 0 || falls != 1) begin
      miscompares++;
      $display("FAIL clean_fall got edge=%0d rises=%0d falls=%0d want %0d 0 1", first, rises, falls, 2 + SC);
    end
  endtask

  task automatic test_glitch();
    int changes = 0;
    for (int i = 0; i < SC - 1; i++) begin
      tick(1'b1, 1'b1);
      changes += int'(d_clean) + int'(rise_pulse) + int'(fall_pulse);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1);
      changes += int'(d_clean) + int'(rise_pulse) + int'(fall_pulse);
    end
    vectors++;
    if (changes != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch got changes=%0d busy=%b want 0 0", changes, busy);
    end
  endtask

  task automatic test_chatter();
    int pulses = 0;
    int first, rises, falls, bc;
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(logic'(i % 2 == 0), 1'b1);
      pulses += int'(rise_pulse) + int'(fall_pulse);
    end
    vectors++;
    if (pulses != 0 || max_cnt > 1) begin
      miscompares++;
      $display("FAIL chatter got pulses=%0d max_cnt=%0d want 0 <=1", pulses, max_cnt);
    end
    hold_until(1'b1, first, rises, falls, bc);
    vectors++;
    if (first != 2 + SC || rises != 1) begin
      miscompares++;
      $display("FAIL chatter_hold got edge=%0d rises=%0d want %0d 1", first, rises, 2 + SC);
    end
  endtask

  task automatic test_reset_mid_qual();
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    vectors++;
    if (dut.state !== QUAL_HI || dut.cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL mid_qual_setup got state=%0d cnt=%0d want %0d 2", dut.state, dut.cnt, QUAL_HI);
    end
    tick(1'b1, 1'b0);
    vectors++;
    if ({d_clean, rise_pulse, fall_pulse, busy} !== 4'b0000 || dut.cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_qual_reset got %b%b%b%b cnt=%0d want 0000 0",
               d_clean, rise_pulse, fall_pulse, busy, dut.cnt);
    end
  endtask

  task automatic test_requalify();
    int first, rises, falls, bc;
    hold_until(1'b1, first, rises, falls, bc);
    vectors++;
    if (first != 2 + SC || rises != 1 || falls != 0) begin
      miscompares++;
      $display("FAIL requalify got edge=%0d rises=%0d falls=%0d want %0d 1 0", first, rises, falls, 2 + SC);
    end
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    for (int n = 0; n < 120; n++) begin
      int len = int'($urandom_range(1, 2 * SC + 2));
      lvl = ~lvl;
      for (int i = 0; i < len; i++) tick(lvl, ($urandom_range(0, 63) != 0));
    end
  endtask

  initial begin
    m_dly[0] = 1'b0; m_dly[1] = 1'b0;
    m_clean = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; max_cnt = 0;
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_chatter();
    test_reset_mid_qual();
    test_requalify();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/d_input_debouncer.md
D_INPUT_DEBOUNCER -- requirements
Module: d_input_debouncer

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive synchronized cycles a new level must hold before it is accepted (legal range 2..65535).
REQ-002 The block SHALL have parameter CNT_W, default 16, the stability counter width; it must satisfy 2^CNT_W > STABLE_CYCLES.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 din  input  1  raw asynchronous level, such as a switch or pin.
REQ-006 d_clean  output  1  debounced level; drives the d input of the downstream flip-flop stage.
REQ-007 rise_pulse  output  1  one-cycle strobe when d_clean goes 0->1.
REQ-008 fall_pulse  output  1  one-cycle strobe when d_clean goes 1->0.
REQ-009 busy  output  1  high while a candidate level change is being qualified.

Function
REQ-010 The block SHALL pass din through a two-flop synchronizer (sync1, then sync2); only sync2 SHALL feed the rest of the logic.
REQ-011 The FSM SHALL have exactly four states:
- STABLE_LO
- QUAL_HI
- STABLE_HI
- QUAL_LO
REQ-012 From STABLE_LO, sync2=1 SHALL move the FSM to QUAL_HI with cnt=1; from STABLE_HI, sync2=0 SHALL move it to QUAL_LO with cnt=1.
REQ-013 In QUAL_HI, each edge with sync2=1 SHALL increment cnt.
REQ-014 In QUAL_HI, an edge with sync2=1 and cnt=STABLE_CYCLES-1 SHALL move the FSM to STABLE_HI, set d_clean=1 and clear cnt.
REQ-015 In QUAL_HI, an edge with sync2=0 SHALL abort: the FSM returns to STABLE_LO, cnt clears, and d_clean is unchanged.
REQ-016 QUAL_LO SHALL mirror REQ-013..015 with the polarities inverted.
REQ-017 Latency: once din holds a new level, d_clean SHALL change on rising edge 2+STABLE_CYCLES, counting as edge 1 the first edge that samples the new din.
REQ-018 rise_pulse and fall_pulse SHALL be registered, asserted only in the single cycle in which d_clean first shows its new value, and never both high in the same cycle.
REQ-019 busy SHALL be 1 exactly when the state is QUAL_HI or QUAL_LO.
REQ-020 The counter SHALL saturate and never wrap; a wrap is unreachable under REQ-002, and the bench SHALL assert that it never occurs.
REQ-021 A din glitch shorter than STABLE_CYCLES synchronized cycles SHALL produce no change on d_clean and no pulse.
REQ-022 If an abort and a re-qualify coincide (sync2 toggles every cycle), the FSM SHALL alternate between the stable and qualify states with cnt never exceeding 1.

Reset
REQ-023 When rst_n=0 at a rising edge, the block SHALL set sync1=0, sync2=0, state=STABLE_LO, cnt=0, d_clean=0, rise_pulse=0, fall_pulse=0 and busy=0.
REQ-024 Reset SHALL take priority over every other event, including during QUAL_HI/QUAL_LO or while a pulse is being issued.
REQ-025 A reset during qualification SHALL discard the qualification and emit no pulse.
REQ-026 After rst_n releases with din=1, the first rise_pulse SHALL follow REQ-017 timing.

Structure
REQ-027 A shared package d_ff_pkg SHALL hold:
- the state enumeration (2-bit encoding)
- the default STABLE_CYCLES and CNT_W constants
REQ-028 The synchronizer SHALL be one sub-module, sync_2ff, with ports clk, rst_n, async_in and sync_out, reset to 0; the FSM and counter SHALL remain in d_input_debouncer.
REQ-029 The design SHALL contain no latches, no combinational output paths from din, and no async reset.

Verification (STABLE_CYCLES=4)
REQ-030 Reset then clean rise: rst_n low for 3 cycles, release, din 0->1 held -> d_clean=1 on edge 6 after the first sampling edge, rise_pulse high for exactly 1 cycle, busy high for 3 cycles beforehand.
REQ-031 Glitch rejection: din high for 3 cycles, then low -> d_clean stays 0, no pulse, busy returns to 0.
REQ-032 Clean fall: from d_clean=1, din 1->0 held -> d_clean=0 after 6 edges, fall_pulse high for 1 cycle, rise_pulse stays 0.
REQ-033 Chatter: din toggles every cycle for 20 cycles, then holds 1 -> no pulses during chatter, cnt never exceeds 1, a single rise_pulse 6 edges after the hold begins.
REQ-034 Reset mid-qualification: din high, rst_n asserted in QUAL_HI with cnt=2 -> all outputs 0 on the next edge, no pulse.
REQ-035 Reset then re-qualify: release rst_n after REQ-034 with din still high -> rise_pulse per REQ-017.
